sb_drain: RTL and testbench

SB_DRAIN -- requirements
Module: sb_drain

---
 rtl/sb_drain_if.sv | 48 ++++
 rtl/sb_drain.sv | 133 +++++++++++++
 tb/tb_sb_drain.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sb_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sb_drain_if                                                     |
// | Brief    : Store-buffer head, dcache write port and bus write channel.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface sb_drain_if #(
  parameter int WAY_NUM = 2
);
  logic               commit_store_i;
  logic               sb_valid_i;
  logic [31:0]        sb_addr_i;
  logic [31:0]        sb_wdata_i;
  logic [3:0]         sb_wstrb_i;
  logic               sb_uncached_i;
  logic [WAY_NUM-1:0] sb_hit_i;
  logic               sb_ready_o;
  logic [WAY_NUM-1:0] dc_we_o;
  logic [31:0]        dc_addr_o;
  logic [31:0]        dc_wdata_o;
  logic [3:0]         dc_strb_o;
  logic               bus_req_valid_o;
  logic               bus_req_ready_i;
  logic [31:0]        bus_addr_o;
  logic [31:0]        bus_wdata_o;
  logic [3:0]         bus_strb_o;
  logic               bus_resp_valid_i;
  logic               busy_o;
  logic [31:0]        perf_hit_cnt_o;
  logic [31:0]        perf_bus_cnt_o;

  modport master (
    input  commit_store_i, sb_valid_i, sb_addr_i, sb_wdata_i, sb_wstrb_i,
           sb_uncached_i, sb_hit_i, bus_req_ready_i, bus_resp_valid_i,
    output sb_ready_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_strb_o,
           bus_req_valid_o, bus_addr_o, bus_wdata_o, bus_strb_o,
           busy_o, perf_hit_cnt_o, perf_bus_cnt_o
  );

  modport slave (
    output commit_store_i, sb_valid_i, sb_addr_i, sb_wdata_i, sb_wstrb_i,
           sb_uncached_i, sb_hit_i, bus_req_ready_i, bus_resp_valid_i,
    input  sb_ready_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_strb_o,
           bus_req_valid_o, bus_addr_o, bus_wdata_o, bus_strb_o,
           busy_o, perf_hit_cnt_o, perf_bus_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/sb_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sb_drain                                                        |
// | Brief    : Drains committed stores one at a time to dcache (hit) or bus.   |
// |            Optional SB_DRAIN_PERF_CNT_EN builds hit/bus drain counters.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module sb_drain #(
  parameter int WAY_NUM = 2,
  parameter int SB_SIZE = 4
) (
  input  wire              clk,
  input  wire              rst,
  sb_drain_if.master       sif
);
  localparam int CW = $clog2(SB_SIZE + 1);
  localparam logic [CW-1:0] c_sb_full = CW'(SB_SIZE);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_hit_wr   = 2'd1;
  localparam logic [1:0] c_st_bus_req  = 2'd2;
  localparam logic [1:0] c_st_bus_wait = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CW-1:0]      r_pending;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_strb;
  logic [WAY_NUM-1:0] r_hit;

  logic               w_ready;
  logic               w_pop;
  logic               w_is_hit;
  logic [WAY_NUM-1:0] w_dc_we;
  logic               w_bus_valid;
  logic               w_busy;

  assign w_pop    = sif.sb_valid_i & w_ready;
  assign w_is_hit = (|sif.sb_hit_i) & ~sif.sb_uncached_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:     if (w_pop) w_state_nxt = w_is_hit ? c_st_hit_wr : c_st_bus_req;
      c_st_hit_wr:   w_state_nxt = c_st_idle;
      c_st_bus_req:  if (sif.bus_req_ready_i) w_state_nxt = c_st_bus_wait;
      c_st_bus_wait: if (sif.bus_resp_valid_i) w_state_nxt = c_st_idle;
      default:       w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == c_st_idle) && (r_pending != '0);
    w_dc_we     = '0;
    w_bus_valid = 1'b0;
    w_busy      = (r_pending != '0) || (r_state != c_st_idle);
    // An all-zero strobe is a no-op store: keep the SRAM untouched.
    if (r_state == c_st_hit_wr && (|r_strb)) w_dc_we = r_hit;
    if (r_state == c_st_bus_req)             w_bus_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      case ({sif.commit_store_i, w_pop})
        2'b10:   if (r_pending != c_sb_full) r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_hit   <= '0;
    end else if (w_pop) begin
      r_addr  <= sif.sb_addr_i;
      r_wdata <= sif.sb_wdata_i;
      r_strb  <= sif.sb_wstrb_i;
      r_hit   <= sif.sb_hit_i;
    end
  end

  assign sif.sb_ready_o      = w_ready;
  assign sif.dc_we_o         = w_dc_we;
  assign sif.dc_addr_o       = r_addr;
  assign sif.dc_wdata_o      = r_wdata;
  assign sif.dc_strb_o       = r_strb;
  assign sif.bus_req_valid_o = w_bus_valid;
  assign sif.bus_addr_o      = r_addr;
  assign sif.bus_wdata_o     = r_wdata;
  assign sif.bus_strb_o      = r_strb;
  assign sif.busy_o          = w_busy;

`ifdef SB_DRAIN_PERF_CNT_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_hit <= '0;
      r_perf_bus <= '0;
    end else begin
      if (r_state == c_st_idle && w_pop && w_is_hit)      r_perf_hit <= r_perf_hit + 32'd1;
      if (r_state == c_st_bus_req && sif.bus_req_ready_i) r_perf_bus <= r_perf_bus + 32'd1;
    end
  end

  assign sif.perf_hit_cnt_o = r_perf_hit;
  assign sif.perf_bus_cnt_o = r_perf_bus;
`else
  assign sif.perf_hit_cnt_o = '0;
  assign sif.perf_bus_cnt_o = '0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(sif.commit_store_i && !w_pop && r_pending == c_sb_full));

  a_head_valid: assert property (@(posedge clk) disable iff (rst)
    !(w_ready && !sif.sb_valid_i));

endmodule
`default_nettype wire

// File: tb/tb_sb_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sb_drain                                                     |
// | Brief    : Directed self-checking bench for sb_drain.                      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_sb_drain;
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   exp_hit_drains;
  int   exp_bus_drains;

  sb_drain_if #(.WAY_NUM(2)) sif ();

  sb_drain #(.WAY_NUM(2), .SB_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (sif.sb_ready_o !== 1'b0) begin failed++; $display("FAIL reset_ready: got %0h expected 0", sif.sb_ready_o); end
    tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL reset_dc_we: got %0h expected 0", sif.dc_we_o); end
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL reset_bus_valid: got %0h expected 0", sif.bus_req_valid_o); end
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0h expected 0", sif.busy_o); end
    tests++; if (sif.dc_addr_o !== 32'h0) begin failed++; $display("FAIL reset_dc_addr: got %0h expected 0", sif.dc_addr_o); end
    tests++; if (sif.perf_hit_cnt_o !== 32'h0) begin failed++; $display("FAIL reset_perf_hit: got %0h expected 0", sif.perf_hit_cnt_o); end
    tests++; if (dut.r_pending !== 3'd0) begin failed++; $display("FAIL reset_pending: got %0d expected 0", dut.r_pending); end
    rst = 1'b0;
  endtask

  task automatic test_hit;
    sif.sb_addr_i      = 32'h0000_1004;
    sif.sb_wdata_i     = 32'hDEAD_BEEF;
    sif.sb_wstrb_i     = 4'hF;
    sif.sb_hit_i       = 2'b01;
    sif.sb_uncached_i  = 1'b0;
    sif.sb_valid_i     = 1'b1;
    sif.commit_store_i = 1'b1;
    tick();
    sif.commit_store_i = 1'b0;
    tests++; if (sif.sb_ready_o !== 1'b1) begin failed++; $display("FAIL hit_pop_ready: got %0h expected 1", sif.sb_ready_o); end
    tick();
    sif.sb_valid_i = 1'b0;
    exp_hit_drains++;
    tests++; if (sif.dc_we_o !== 2'b01) begin failed++; $display("FAIL hit_dc_we: got %0h expected 1", sif.dc_we_o); end
    tests++; if (sif.dc_addr_o !== 32'h0000_1004) begin failed++; $display("FAIL hit_dc_addr: got %0h expected 1004", sif.dc_addr_o); end
    tests++; if (sif.dc_wdata_o !== 32'hDEAD_BEEF) begin failed++; $display("FAIL hit_dc_wdata: got %0h expected deadbeef", sif.dc_wdata_o); end
    tests++; if (sif.sb_ready_o !== 1'b0) begin failed++; $display("FAIL hit_ready_in_wr: got %0h expected 0", sif.sb_ready_o); end
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL hit_no_bus: got %0h expected 0", sif.bus_req_valid_o); end
    tick();
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL hit_idle_busy: got %0h expected 0", sif.busy_o); end
    tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL hit_we_drop: got %0h expected 0", sif.dc_we_o); end
  endtask

  task automatic test_uncached;
    sif.sb_addr_i       = 32'hBFD0_0000;
    sif.sb_wdata_i      = 32'h1234_5678;
    sif.sb_wstrb_i      = 4'h1;
    sif.sb_hit_i        = 2'b01;
    sif.sb_uncached_i   = 1'b1;
    sif.bus_req_ready_i = 1'b0;
    sif.sb_valid_i      = 1'b1;
    sif.commit_store_i  = 1'b1;
    tick();
    sif.commit_store_i = 1'b0;
    tests++; if (sif.sb_ready_o !== 1'b1) begin failed++; $display("FAIL unc_pop_ready: got %0h expected 1", sif.sb_ready_o); end
    tick();
    sif.sb_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (sif.bus_req_valid_o !== 1'b1) begin failed++; $display("FAIL unc_req_valid[%0d]: got %0h expected 1", i, sif.bus_req_valid_o); end
      tests++; if (sif.bus_addr_o !== 32'hBFD0_0000) begin failed++; $display("FAIL unc_bus_addr[%0d]: got %0h expected bfd00000", i, sif.bus_addr_o); end
      tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL unc_dc_we[%0d]: got %0h expected 0", i, sif.dc_we_o); end
      if (i == 0) begin
        tests++; if (sif.bus_wdata_o !== 32'h1234_5678) begin failed++; $display("FAIL unc_bus_wdata: got %0h expected 12345678", sif.bus_wdata_o); end
        tests++; if (sif.bus_strb_o !== 4'h1) begin failed++; $display("FAIL unc_bus_strb: got %0h expected 1", sif.bus_strb_o); end
      end
      if (i == 3) begin
        sif.bus_req_ready_i  = 1'b1;
        sif.bus_resp_valid_i = 1'b1;
      end
      tick();
    end
    exp_bus_drains++;
    sif.bus_req_ready_i  = 1'b0;
    sif.bus_resp_valid_i = 1'b0;
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL unc_req_drop: got %0h expected 0", sif.bus_req_valid_o); end
    tests++; if (sif.busy_o !== 1'b1) begin failed++; $display("FAIL unc_wait_busy: got %0h expected 1", sif.busy_o); end
    tick();
    tests++; if (sif.busy_o !== 1'b1) begin failed++; $display("FAIL unc_still_wait: got %0h expected 1", sif.busy_o); end
    sif.bus_resp_valid_i = 1'b1;
    tick();
    sif.bus_resp_valid_i = 1'b0;
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL unc_done_idle: got %0h expected 0", sif.busy_o); end
  endtask

  task automatic test_miss;
    sif.sb_addr_i      = 32'h0000_2000;
    sif.sb_wdata_i     = 32'hCAFE_F00D;
    sif.sb_wstrb_i     = 4'h3;
    sif.sb_hit_i       = 2'b00;
    sif.sb_uncached_i  = 1'b0;
    sif.sb_valid_i     = 1'b1;
    sif.commit_store_i = 1'b1;
    tick();
    sif.commit_store_i = 1'b0;
    tick();
    sif.sb_valid_i = 1'b0;
    tests++; if (sif.bus_req_valid_o !== 1'b1) begin failed++; $display("FAIL miss_req_valid: got %0h expected 1", sif.bus_req_valid_o); end
    tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL miss_dc_we_req: got %0h expected 0", sif.dc_we_o); end
    sif.bus_req_ready_i = 1'b1;
    tick();
    exp_bus_drains++;
    sif.bus_req_ready_i = 1'b0;
    tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL miss_dc_we_wait: got %0h expected 0", sif.dc_we_o); end
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL miss_req_drop: got %0h expected 0", sif.bus_req_valid_o); end
    sif.bus_resp_valid_i = 1'b1;
    tick();
    sif.bus_resp_valid_i = 1'b0;
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL miss_idle: got %0h expected 0", sif.busy_o); end
  endtask

  task automatic test_back_to_back;
    int         exp_pend [10];
    logic       exp_rdy  [10];
    logic [1:0] exp_we   [10];
    exp_pend = '{0, 1, 1, 2, 2, 2, 1, 1, 0, 0};
    exp_rdy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_we   = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    sif.sb_addr_i     = 32'h0000_3000;
    sif.sb_wdata_i    = 32'h0BAD_C0DE;
    sif.sb_wstrb_i    = 4'hF;
    sif.sb_hit_i      = 2'b10;
    sif.sb_uncached_i = 1'b0;
    sif.sb_valid_i    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests++; if (sif.sb_ready_o !== exp_rdy[c]) begin failed++; $display("FAIL b2b_ready[%0d]: got %0h expected %0h", c, sif.sb_ready_o, exp_rdy[c]); end
      tests++; if (dut.r_pending !== 3'(exp_pend[c])) begin failed++; $display("FAIL b2b_pending[%0d]: got %0d expected %0d", c, dut.r_pending, exp_pend[c]); end
      tests++; if (sif.dc_we_o !== exp_we[c]) begin failed++; $display("FAIL b2b_dc_we[%0d]: got %0h expected %0h", c, sif.dc_we_o, exp_we[c]); end
      sif.commit_store_i = (c < 4);
      tick();
    end
    exp_hit_drains += 4;
    sif.commit_store_i = 1'b0;
    sif.sb_valid_i     = 1'b0;
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL b2b_idle: got %0h expected 0", sif.busy_o); end
  endtask

  task automatic test_perf;
    int eh;
    int eb;
`ifdef SB_DRAIN_PERF_CNT_EN
    eh = exp_hit_drains;
    eb = exp_bus_drains;
`else
    eh = 0;
    eb = 0;
`endif
    tests++; if (sif.perf_hit_cnt_o !== 32'(eh)) begin failed++; $display("FAIL perf_hit: got %0d expected %0d", sif.perf_hit_cnt_o, eh); end
    tests++; if (sif.perf_bus_cnt_o !== 32'(eb)) begin failed++; $display("FAIL perf_bus: got %0d expected %0d", sif.perf_bus_cnt_o, eb); end
  endtask

  task automatic test_reset_mid_bus;
    sif.sb_addr_i      = 32'h0000_4000;
    sif.sb_wdata_i     = 32'h5555_AAAA;
    sif.sb_wstrb_i     = 4'hF;
    sif.sb_hit_i       = 2'b00;
    sif.sb_uncached_i  = 1'b0;
    sif.sb_valid_i     = 1'b1;
    sif.commit_store_i = 1'b1;
    tick();
    sif.commit_store_i = 1'b0;
    tick();
    sif.sb_valid_i      = 1'b0;
    sif.bus_req_ready_i = 1'b1;
    tick();
    sif.bus_req_ready_i = 1'b0;
    tests++; if (sif.busy_o !== 1'b1) begin failed++; $display("FAIL rmid_in_wait: got %0h expected 1", sif.busy_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL rmid_busy: got %0h expected 0", sif.busy_o); end
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL rmid_req: got %0h expected 0", sif.bus_req_valid_o); end
    tests++; if (sif.bus_addr_o !== 32'h0) begin failed++; $display("FAIL rmid_addr: got %0h expected 0", sif.bus_addr_o); end
    tests++; if (sif.perf_bus_cnt_o !== 32'h0) begin failed++; $display("FAIL rmid_perf: got %0d expected 0", sif.perf_bus_cnt_o); end
    sif.bus_resp_valid_i = 1'b1;
    tick();
    sif.bus_resp_valid_i = 1'b0;
    tests++; if (sif.busy_o !== 1'b0) begin failed++; $display("FAIL rmid_resp_ignored: got %0h expected 0", sif.busy_o); end
    tests++; if (dut.r_pending !== 3'd0) begin failed++; $display("FAIL rmid_pending: got %0d expected 0", dut.r_pending); end
    tests++; if (sif.dc_we_o !== 2'b00) begin failed++; $display("FAIL rmid_dc_we: got %0h expected 0", sif.dc_we_o); end
    tick();
    tests++; if (sif.bus_req_valid_o !== 1'b0) begin failed++; $display("FAIL rmid_no_req: got %0h expected 0", sif.bus_req_valid_o); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    exp_hit_drains = 0;
    exp_bus_drains = 0;
    rst = 1'b1;
    sif.commit_store_i   = 1'b0;
    sif.sb_valid_i       = 1'b0;
    sif.sb_addr_i        = '0;
    sif.sb_wdata_i       = '0;
    sif.sb_wstrb_i       = '0;
    sif.sb_uncached_i    = 1'b0;
    sif.sb_hit_i         = '0;
    sif.bus_req_ready_i  = 1'b0;
    sif.bus_resp_valid_i = 1'b0;
    test_reset();
    test_hit();
    test_uncached();
    test_miss();
    test_back_to_back();
    test_perf();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
